// File: rtl/ddram_port_arbiter.sv
// ddram_port_arbiter
// Shares one single-beat MiSTer DDRAM port among NCH request/ack clients.
// Winner selection is fixed-priority or round-robin. A designated urgent
// channel overrides both. Reads that never return data are abandoned by a
// watchdog, which flags the error on the channel and in a sticky status bit.
// Only one transaction is in flight at a time.

module ddram_port_arbiter #(
  parameter int NCH       = 4,
  parameter int ADDR_W    = 29,
  parameter int MODE      = 1,
  parameter int URGENT_CH = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic [NCH-1:0]        ch_req,
  input  logic [NCH-1:0]        ch_write,
  input  logic [NCH*ADDR_W-1:0] ch_addr,
  input  logic [NCH*64-1:0]     ch_wdata,
  input  logic [NCH*8-1:0]      ch_be,
  output logic [NCH-1:0]        ch_ack,
  output logic [NCH-1:0]        ch_done,
  output logic [NCH-1:0]        ch_err,
  output logic [63:0]           ch_rdata,
  output logic                  timeout_seen,

  output logic                  DDRAM_CLK,
  input  logic                  DDRAM_BUSY,
  output logic [7:0]            DDRAM_BURSTCNT,
  output logic [28:0]           DDRAM_ADDR,
  output logic                  DDRAM_RD,
  output logic                  DDRAM_WE,
  output logic [63:0]           DDRAM_DIN,
  output logic [7:0]            DDRAM_BE,
  input  logic [63:0]           DDRAM_DOUT,
  input  logic                  DDRAM_DOUT_READY
);

  localparam int          PTR_W   = $clog2(NCH);
  localparam bit          URG_EN  = (URGENT_CH >= 0) && (URGENT_CH < NCH);
  localparam int          URG_IDX = URG_EN ? URGENT_CH : 0;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RWAIT
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  gnt;
  logic              cmd_write;
  logic [15:0]       wd_cnt;

  logic [NCH-1:0]    eligible;
  logic [PTR_W-1:0]  fixed_win;
  logic [PTR_W-1:0]  rr_win;
  logic              rr_found;
  logic [PTR_W:0]    rr_sum;
  logic [PTR_W-1:0]  rr_idx;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  next_ptr;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [63:0]       sel_wdata;
  logic [7:0]        sel_be;

  assign DDRAM_CLK      = clk;
  assign DDRAM_BURSTCNT = 8'd1;

  // A channel whose ack is showing this cycle is still holding ch_req while
  // the client reacts, so it must not be granted a second time.
  assign eligible = ch_req & ~ch_ack;

  // Fixed-priority pick: the lowest-numbered eligible channel.
  always_comb begin
    fixed_win = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        fixed_win = PTR_W'(i);
      end
    end
  end

  // Round-robin pick: first eligible channel at or after ptr, wrapping at NCH.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      rr_sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (rr_sum >= (PTR_W+1)'(NCH)) begin
        rr_sum = rr_sum - (PTR_W+1)'(NCH);
      end
      rr_idx = rr_sum[PTR_W-1:0];
      if (!rr_found && eligible[rr_idx]) begin
        rr_win   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  // Urgent channel overrides both policies; otherwise MODE chooses.
  always_comb begin
    if (URG_EN && eligible[URG_IDX]) begin
      win = PTR_W'(URG_IDX);
    end else if (MODE == 0) begin
      win = fixed_win;
    end else begin
      win = rr_win;
    end
  end

  assign next_ptr = (win == PTR_W'(NCH - 1)) ? '0 : win + PTR_W'(1);

  // Route the winning channel's command fields to the issue registers.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (win == PTR_W'(i)) begin
        sel_write = ch_write[i];
        sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = ch_wdata[i*64 +: 64];
        sel_be    = ch_be[i*8 +: 8];
      end
    end
  end

  // Arbiter FSM: grant, hold the command until accepted, then wait for data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt          <= '0;
      cmd_write    <= 1'b0;
      wd_cnt       <= '0;
      DDRAM_RD     <= 1'b0;
      DDRAM_WE     <= 1'b0;
      DDRAM_ADDR   <= '0;
      DDRAM_DIN    <= '0;
      DDRAM_BE     <= '0;
      ch_ack       <= '0;
      ch_done      <= '0;
      ch_err       <= '0;
      ch_rdata     <= '0;
      timeout_seen <= 1'b0;
    end else begin
      ch_ack  <= '0;
      ch_done <= '0;
      ch_err  <= '0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            gnt        <= win;
            ptr        <= next_ptr;
            cmd_write  <= sel_write;
            DDRAM_WE   <= sel_write;
            DDRAM_RD   <= ~sel_write;
            DDRAM_ADDR <= 29'(sel_addr);
            DDRAM_DIN  <= sel_wdata;
            DDRAM_BE   <= sel_be;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (!DDRAM_BUSY) begin
            DDRAM_RD    <= 1'b0;
            DDRAM_WE    <= 1'b0;
            ch_ack[gnt] <= 1'b1;
            if (cmd_write) begin
              ch_done[gnt] <= 1'b1;
              state        <= IDLE;
            end else begin
              wd_cnt <= '0;
              state  <= RWAIT;
            end
          end
        end
        RWAIT: begin
          if (DDRAM_DOUT_READY) begin
            ch_rdata     <= DDRAM_DOUT;
            ch_done[gnt] <= 1'b1;
            state        <= IDLE;
          end else if (wd_cnt == TO_LAST) begin
            ch_done[gnt] <= 1'b1;
            ch_err[gnt]  <= 1'b1;
            timeout_seen <= 1'b1;
            state        <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_port_arbiter.sv
// tb_ddram_port_arbiter
// Randomised and directed transactions against a transaction-level model of
// the arbiter: the model knows pending requests, the grant pointer, the last
// read data and the sticky timeout bit, and predicts every visible output.

module tb_ddram_port_arbiter;

  localparam int NCH       = 4;
  localparam int ADDR_W    = 29;
  localparam int MODE      = 1;
  localparam int URGENT_CH = 3;
  localparam int TIMEOUT   = 255;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NCH-1:0]        ch_req;
  logic [NCH-1:0]        ch_write;
  logic [NCH*ADDR_W-1:0] ch_addr;
  logic [NCH*64-1:0]     ch_wdata;
  logic [NCH*8-1:0]      ch_be;
  logic [NCH-1:0]        ch_ack;
  logic [NCH-1:0]        ch_done;
  logic [NCH-1:0]        ch_err;
  logic [63:0]           ch_rdata;
  logic                  timeout_seen;
  logic                  DDRAM_CLK;
  logic                  DDRAM_BUSY;
  logic [7:0]            DDRAM_BURSTCNT;
  logic [28:0]           DDRAM_ADDR;
  logic                  DDRAM_RD;
  logic                  DDRAM_WE;
  logic [63:0]           DDRAM_DIN;
  logic [7:0]            DDRAM_BE;
  logic [63:0]           DDRAM_DOUT;
  logic                  DDRAM_DOUT_READY;

  ddram_port_arbiter #(
    .NCH(NCH), .ADDR_W(ADDR_W), .MODE(MODE), .URGENT_CH(URGENT_CH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ch_req(ch_req), .ch_write(ch_write), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_be(ch_be),
    .ch_ack(ch_ack), .ch_done(ch_done), .ch_err(ch_err), .ch_rdata(ch_rdata),
    .timeout_seen(timeout_seen),
    .DDRAM_CLK(DDRAM_CLK), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_RD(DDRAM_RD), .DDRAM_WE(DDRAM_WE),
    .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_DOUT(DDRAM_DOUT),
    .DDRAM_DOUT_READY(DDRAM_DOUT_READY)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NCH-1:0]    cl_req;
  logic [NCH-1:0]    cl_write;
  logic [ADDR_W-1:0] cl_addr  [NCH];
  logic [63:0]       cl_wdata [NCH];
  logic [7:0]        cl_be    [NCH];

  int          mptr;
  logic [63:0] mrdata;
  logic        mtseen;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NCH; i++) begin
      ch_req[i]                  = cl_req[i];
      ch_write[i]                = cl_write[i];
      ch_addr[i*ADDR_W +: ADDR_W] = cl_addr[i];
      ch_wdata[i*64 +: 64]       = cl_wdata[i];
      ch_be[i*8 +: 8]            = cl_be[i];
    end
  endtask

  task automatic newRequest(input int c, input int wr);
    cl_req[c]   = 1'b1;
    cl_write[c] = (wr < 0) ? 1'($urandom % 2) : 1'(wr);
    cl_addr[c]  = ADDR_W'($urandom);
    cl_wdata[c] = {$urandom, $urandom};
    cl_be[c]    = 8'($urandom);
    applyStimulus();
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Spec rule: urgent wins, else lowest index (MODE 0) or first from ptr upward.
  function automatic int pickWinner(input logic [NCH-1:0] p, input int ptr);
    if (URGENT_CH < NCH && p[URGENT_CH]) return URGENT_CH;
    if (MODE == 0) begin
      for (int i = 0; i < NCH; i++) if (p[i]) return i;
    end else begin
      for (int k = 0; k < NCH; k++) if (p[(ptr + k) % NCH]) return (ptr + k) % NCH;
    end
    return -1;
  endfunction

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_rd"}, DDRAM_RD, 1'b0);
    checkOutput({tag, "_we"}, DDRAM_WE, 1'b0);
    checkOutput({tag, "_ack"}, ch_ack, '0);
    checkOutput({tag, "_done"}, ch_done, '0);
    checkOutput({tag, "_err"}, ch_err, '0);
    checkOutput({tag, "_rdata"}, ch_rdata, mrdata);
    checkOutput({tag, "_tseen"}, timeout_seen, mtseen);
  endtask

  task automatic checkResetValues(input string tag);
    checkQuiet(tag);
    checkOutput({tag, "_addr"}, DDRAM_ADDR, '0);
    checkOutput({tag, "_din"}, DDRAM_DIN, '0);
    checkOutput({tag, "_be"}, DDRAM_BE, '0);
    checkOutput({tag, "_burst"}, DDRAM_BURSTCNT, 8'd1);
  endtask

  task automatic idleTick();
    DDRAM_DOUT_READY = 1'($urandom % 2);
    DDRAM_DOUT       = {$urandom, $urandom};
    tick();
    DDRAM_DOUT_READY = 1'b0;
    checkQuiet("idle");
  endtask

  // One full transaction, starting in an arbitration cycle with requests pending.
  // lat = cycles from acceptance to DOUT_READY; 0 means data never arrives.
  task automatic serveOne(input int nbusy, input int lat, input logic [NCH-1:0] extra,
                          input int extra_dir, input logic [63:0] rdat,
                          output int w, output logic wr);
    logic [ADDR_W-1:0] ea;
    logic [63:0]       ed;
    logic [7:0]        eb;
    logic [NCH-1:0]    onehot;
    logic [NCH-1:0]    ext;
    int                limit;
    w = pickWinner(cl_req, mptr);
    if (w < 0) begin
      checkOutput("serve_no_request", 64'd0, 64'd1);
      wr = 1'b0;
      return;
    end
    mptr   = (w + 1) % NCH;
    wr     = cl_write[w];
    ea     = cl_addr[w];
    ed     = cl_wdata[w];
    eb     = cl_be[w];
    onehot = NCH'(1) << w;
    DDRAM_BUSY = 1'b0;
    tick();
    checkOutput("cmd_we", DDRAM_WE, wr);
    checkOutput("cmd_rd", DDRAM_RD, !wr);
    checkOutput("cmd_addr", DDRAM_ADDR, 29'(ea));
    checkOutput("cmd_din", DDRAM_DIN, ed);
    checkOutput("cmd_be", DDRAM_BE, eb);
    checkOutput("cmd_ack_early", ch_ack, '0);
    ext = extra & ~cl_req & ~onehot;
    for (int i = 0; i < NCH; i++) if (ext[i]) newRequest(i, extra_dir);
    for (int b = 0; b < nbusy; b++) begin
      DDRAM_BUSY       = 1'b1;
      DDRAM_DOUT_READY = 1'($urandom % 2);
      DDRAM_DOUT       = {$urandom, $urandom};
      tick();
      checkOutput("hold_we", DDRAM_WE, wr);
      checkOutput("hold_rd", DDRAM_RD, !wr);
      checkOutput("hold_addr", DDRAM_ADDR, 29'(ea));
      checkOutput("hold_ack", ch_ack, '0);
      checkOutput("hold_rdata", ch_rdata, mrdata);
    end
    DDRAM_BUSY       = 1'b0;
    DDRAM_DOUT_READY = 1'b0;
    tick();
    checkOutput("acc_we", DDRAM_WE, 1'b0);
    checkOutput("acc_rd", DDRAM_RD, 1'b0);
    checkOutput("acc_ack", ch_ack, onehot);
    checkOutput("acc_done", ch_done, wr ? onehot : '0);
    checkOutput("acc_err", ch_err, '0);
    cl_req[w] = 1'b0;
    applyStimulus();
    if (!wr) begin
      limit = (lat == 0) ? TIMEOUT : lat;
      for (int j = 1; j <= limit; j++) begin
        DDRAM_DOUT_READY = (lat != 0) && (j == limit);
        DDRAM_DOUT       = (j == limit) ? rdat : {$urandom, $urandom};
        tick();
        if (j < limit) begin
          checkOutput("rwait_done", ch_done, '0);
        end else if (lat != 0) begin
          mrdata = rdat;
          checkOutput("rd_done", ch_done, onehot);
          checkOutput("rd_err", ch_err, '0);
          checkOutput("rd_data", ch_rdata, mrdata);
        end else begin
          mtseen = 1'b1;
          checkOutput("to_done", ch_done, onehot);
          checkOutput("to_err", ch_err, onehot);
          checkOutput("to_rdata", ch_rdata, mrdata);
        end
      end
      DDRAM_DOUT_READY = 1'b0;
    end
    checkOutput("tseen", timeout_seen, mtseen);
  endtask

  initial begin
    int   w;
    logic wr;
    int   blocked;
    cl_req   = '0;
    cl_write = '0;
    for (int i = 0; i < NCH; i++) begin
      cl_addr[i]  = '0;
      cl_wdata[i] = '0;
      cl_be[i]    = '0;
    end
    applyStimulus();
    DDRAM_BUSY       = 1'b0;
    DDRAM_DOUT_READY = 1'b0;
    DDRAM_DOUT       = '0;
    mptr   = 0;
    mrdata = '0;
    mtseen = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("por");
    reset_n = 1'b1;
    idleTick();

    // Round-robin among ch0..ch2, then wrap from ptr=3 to ch0.
    for (int c = 0; c < 3; c++) newRequest(c, -1);
    serveOne($urandom % 3, 1 + $urandom % 4, 4'b0000, -1, {$urandom, $urandom}, w, wr);
    checkOutput("rr_g0", w, 0);
    serveOne($urandom % 3, 1 + $urandom % 4, 4'b0001, -1, {$urandom, $urandom}, w, wr);
    checkOutput("rr_g1", w, 1);
    serveOne($urandom % 3, 1 + $urandom % 4, 4'b0010, -1, {$urandom, $urandom}, w, wr);
    checkOutput("rr_g2", w, 2);
    serveOne($urandom % 3, 1 + $urandom % 4, 4'b0100, 0, {$urandom, $urandom}, w, wr);
    checkOutput("rr_g3", w, 0);
    serveOne($urandom % 3, 1 + $urandom % 4, 4'b0001, -1, {$urandom, $urandom}, w, wr);
    checkOutput("rr_g4", w, 1);
    serveOne($urandom % 3, 1 + $urandom % 4, 4'b0000, -1, {$urandom, $urandom}, w, wr);
    checkOutput("rr_g5", w, 2);
    newRequest(2, -1);
    serveOne(0, 2, 4'b0000, -1, {$urandom, $urandom}, w, wr);
    checkOutput("rr_wrap", w, 0);
    serveOne(0, 2, 4'b0000, -1, {$urandom, $urandom}, w, wr);
    checkOutput("rr_last", w, 2);
    idleTick();

    // Urgent ch3 raised mid-transaction wins next; round-robin restarts at 0.
    for (int c = 0; c < 3; c++) newRequest(c, -1);
    serveOne(1, 3, 4'b1000, -1, {$urandom, $urandom}, w, wr);
    checkOutput("urg_pre", w, 0);
    serveOne(1, 3, 4'b0001, -1, {$urandom, $urandom}, w, wr);
    checkOutput("urg_win", w, 3);
    serveOne(0, 3, 4'b0000, -1, {$urandom, $urandom}, w, wr);
    checkOutput("urg_resume", w, 0);
    cl_req = '0;
    applyStimulus();
    idleTick();

    // Directed single write on ch1.
    newRequest(1, 1);
    cl_addr[1]  = 29'h0000123;
    cl_wdata[1] = 64'hDEADBEEF_01234567;
    cl_be[1]    = 8'hFF;
    applyStimulus();
    serveOne(0, 1, '0, -1, '0, w, wr);
    checkOutput("wr_gnt", w, 1);

    // Directed read on ch0 with 3 busy cycles and data 5 cycles after accept.
    newRequest(0, 0);
    serveOne(3, 5, '0, -1, 64'h55AA55AA55AA55AA, w, wr);
    checkOutput("rd_gnt", w, 0);
    checkOutput("rd_value", ch_rdata, 64'h55AA55AA55AA55AA);

    // Read whose data never arrives.
    newRequest(1, 0);
    serveOne(1, 0, '0, -1, {$urandom, $urandom}, w, wr);
    checkOutput("to_sticky", timeout_seen, 1'b1);

    // Random traffic.
    blocked = -1;
    for (int t = 0; t < 150; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!cl_req[c] && c != blocked && ($urandom % 3) == 0) newRequest(c, -1);
      end
      if (cl_req == '0) begin
        idleTick();
        blocked = -1;
      end else begin
        serveOne($urandom % 4, 1 + $urandom % 8, NCH'($urandom), -1, {$urandom, $urandom}, w, wr);
        blocked = wr ? w : -1;
      end
    end
    checkOutput("to_sticky_late", timeout_seen, 1'b1);

    // Reset while a read is waiting for data; the late response is ignored.
    cl_req = '0;
    applyStimulus();
    idleTick();
    newRequest(2, 0);
    tick();
    checkOutput("rst_cmd_rd", DDRAM_RD, 1'b1);
    DDRAM_BUSY = 1'b0;
    tick();
    checkOutput("rst_ack", ch_ack, 4'b0100);
    cl_req[2] = 1'b0;
    applyStimulus();
    tick();
    tick();
    checkOutput("rst_wait_done", ch_done, '0);
    #1 reset_n = 1'b0;
    #1;
    mptr   = 0;
    mrdata = '0;
    mtseen = 1'b0;
    checkResetValues("rst_mid");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    DDRAM_DOUT_READY = 1'b1;
    DDRAM_DOUT       = {$urandom, $urandom};
    tick();
    checkOutput("late_done", ch_done, '0);
    checkOutput("late_rdata", ch_rdata, '0);
    DDRAM_DOUT_READY = 1'b0;
    tick();
    checkResetValues("rst_post");
    newRequest(1, 1);
    newRequest(2, 0);
    serveOne(0, 2, '0, -1, {$urandom, $urandom}, w, wr);
    checkOutput("rst_ptr0", w, 1);
    serveOne(0, 2, '0, -1, {$urandom, $urandom}, w, wr);
    checkOutput("rst_next", w, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
